// File: rtl/miv_rv32imaf_l1_ahb_ecc_scrub_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | miv_rv32imaf_l1_ahb_ecc_scrub_ctrl : L1 ECC RAM scrub/log controller;     |
// | optional background walker under `RAM_ECC_BG_SCRUB_EN.  Revision: 1.0    |
// +--------------------------------------------------------------------------+
module miv_rv32imaf_l1_ahb_ecc_scrub_ctrl #(
    parameter int CNT_W = 8
`ifdef RAM_ECC_BG_SCRUB_EN
    ,
    parameter int SCRUB_INTERVAL = 1024
`endif
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             c_ren,
    input  logic [6:0]       c_raddr,
    output logic [19:0]      c_rd,
    output logic             c_rvalid,
    output logic             c_rerr,
    input  logic             c_wen,
    input  logic [6:0]       c_waddr,
    input  logic [19:0]      c_wd,
    output logic [6:0]       ram_raddr,
    output logic [6:0]       ram_waddr,
    output logic [19:0]      ram_wd,
    output logic             ram_wen,
    input  logic [19:0]      ram_rd,
    input  logic             ram_sb,
    input  logic             ram_db,
    output logic [CNT_W-1:0] sb_cnt,
    output logic [CNT_W-1:0] db_cnt,
    output logic [6:0]       db_addr,
    output logic             db_irq,
    input  logic             irq_clr,
    output logic             scrub_drop
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_SCRUB_WR = 1'b1
    } state_t;

    state_t      state;
    logic        rd_q;
    logic        src_client_q;
    logic [6:0]  raddr_q;
    logic [6:0]  pend_addr;
    logic [19:0] pend_data;
    logic        sb_ev;
    logic        db_ev;
    logic        scrub_exit;
    logic        bg_issue;

    // A DB flag overrides SB: the corrected-data claim is not trustworthy then.
    assign sb_ev      = rd_q & ram_sb & ~ram_db;
    assign db_ev      = rd_q & ram_db;
    assign scrub_exit = (state == ST_SCRUB_WR) & (~c_wen | (c_waddr == pend_addr));

`ifdef RAM_ECC_BG_SCRUB_EN
    localparam int IV_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    logic [IV_W-1:0] iv_cnt;
    logic            bg_req;
    logic [6:0]      bg_addr;

    assign bg_issue  = bg_req & ~c_ren & (state == ST_IDLE);
    assign ram_raddr = bg_issue ? bg_addr : c_raddr;

    // The interval only runs while no request is outstanding, so a starved
    // request never piles up a second one behind it.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            iv_cnt  <= '0;
            bg_req  <= 1'b0;
            bg_addr <= '0;
        end else begin
            if (bg_issue) begin
                bg_req  <= 1'b0;
                bg_addr <= bg_addr + 7'd1;
            end else if (!bg_req) begin
                if (iv_cnt == IV_W'(SCRUB_INTERVAL - 1)) begin
                    iv_cnt <= '0;
                    bg_req <= 1'b1;
                end else begin
                    iv_cnt <= iv_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign bg_issue  = 1'b0;
    assign ram_raddr = c_raddr;
`endif

    assign c_rd      = ram_rd;
    assign c_rvalid  = rd_q & src_client_q;
    assign c_rerr    = rd_q & src_client_q & ram_db;

    // Client writes always own the write port; the scrub only fills idle slots.
    assign ram_wen   = c_wen | (state == ST_SCRUB_WR);
    assign ram_waddr = c_wen ? c_waddr : pend_addr;
    assign ram_wd    = c_wen ? c_wd    : pend_data;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state        <= ST_IDLE;
            rd_q         <= 1'b0;
            src_client_q <= 1'b0;
            raddr_q      <= '0;
            pend_addr    <= '0;
            pend_data    <= '0;
            sb_cnt       <= '0;
            db_cnt       <= '0;
            db_addr      <= '0;
            db_irq       <= 1'b0;
            scrub_drop   <= 1'b0;
        end else begin
            rd_q         <= c_ren | bg_issue;
            src_client_q <= c_ren;
            raddr_q      <= ram_raddr;
            scrub_drop   <= 1'b0;

            if (sb_ev && (sb_cnt != '1)) begin
                sb_cnt <= sb_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (sb_ev) begin
                        pend_addr <= raddr_q;
                        pend_data <= ram_rd;
                        state     <= ST_SCRUB_WR;
                    end
                end
                ST_SCRUB_WR: begin
                    if (scrub_exit) begin
                        // The slot frees this cycle, so a new SB can take it.
                        if (sb_ev) begin
                            pend_addr <= raddr_q;
                            pend_data <= ram_rd;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (sb_ev && (raddr_q != pend_addr)) begin
                        scrub_drop <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (db_ev) begin
                if (db_cnt != '1) begin
                    db_cnt <= db_cnt + 1'b1;
                end
                if (!db_irq || irq_clr) begin
                    db_addr <= raddr_q;
                end
                db_irq <= 1'b1;
            end else if (irq_clr) begin
                db_irq <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miv_rv32imaf_l1_ahb_ecc_scrub_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_miv_rv32imaf_l1_ahb_ecc_scrub_ctrl : bench for the ECC scrub control.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_miv_rv32imaf_l1_ahb_ecc_scrub_ctrl;

    localparam int CNT_W = 8;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        c_ren, c_wen, irq_clr, ram_sb, ram_db;
    logic [6:0]  c_raddr, c_waddr;
    logic [19:0] c_wd, ram_rd;
    logic [19:0] c_rd, ram_wd;
    logic        c_rvalid, c_rerr, ram_wen, db_irq, scrub_drop;
    logic [6:0]  ram_raddr, ram_waddr, db_addr;
    logic [CNT_W-1:0] sb_cnt, db_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    miv_rv32imaf_l1_ahb_ecc_scrub_ctrl #(
        .CNT_W(CNT_W)
`ifdef RAM_ECC_BG_SCRUB_EN
        , .SCRUB_INTERVAL(4)
`endif
    ) dut (
        .CLK(CLK), .RESETN(RESETN),
        .c_ren(c_ren), .c_raddr(c_raddr), .c_rd(c_rd), .c_rvalid(c_rvalid), .c_rerr(c_rerr),
        .c_wen(c_wen), .c_waddr(c_waddr), .c_wd(c_wd),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wd(ram_wd), .ram_wen(ram_wen),
        .ram_rd(ram_rd), .ram_sb(ram_sb), .ram_db(ram_db),
        .sb_cnt(sb_cnt), .db_cnt(db_cnt), .db_addr(db_addr), .db_irq(db_irq),
        .irq_clr(irq_clr), .scrub_drop(scrub_drop)
    );

    // Reference model: one scrub slot, an outstanding-read marker and the log.
    bit          m_rd, m_pend, m_irq, m_drop;
    logic [6:0]  m_raddr, m_paddr, m_daddr;
    logic [19:0] m_pdata;
    logic [7:0]  m_sb, m_db;

    task automatic model_reset();
        m_rd = 0; m_pend = 0; m_irq = 0; m_drop = 0;
        m_raddr = '0; m_paddr = '0; m_daddr = '0; m_pdata = '0;
        m_sb = '0; m_db = '0;
    endtask

    task automatic model_advance();
        bit sb_ev, db_ev;
        sb_ev  = m_rd && ram_sb && !ram_db;
        db_ev  = m_rd && ram_db;
        m_drop = 0;
        if (m_pend && (!c_wen || c_waddr == m_paddr)) m_pend = 0;
        if (sb_ev) begin
            if (m_sb != 8'hFF) m_sb = m_sb + 8'd1;
            if (!m_pend) begin
                m_pend = 1; m_paddr = m_raddr; m_pdata = ram_rd;
            end else if (m_raddr != m_paddr) begin
                m_drop = 1;
            end
        end
        if (db_ev) begin
            if (m_db != 8'hFF) m_db = m_db + 8'd1;
            if (!m_irq || irq_clr) m_daddr = m_raddr;
            m_irq = 1;
        end else if (irq_clr) begin
            m_irq = 0;
        end
        m_rd = c_ren;
        m_raddr = c_raddr;
    endtask

    // One clock of stimulus; returns 1 ns after the falling edge so both the
    // registered state and the combinational response can be sampled.
    task automatic cyc(input bit ren, input logic [6:0] ra, input bit wen, input logic [6:0] wa,
                       input logic [19:0] wd, input bit clr, input logic [19:0] rd,
                       input bit sb, input bit db);
        model_advance();
        @(negedge CLK);
        c_ren = ren; c_raddr = ra; c_wen = wen; c_waddr = wa; c_wd = wd;
        irq_clr = clr; ram_rd = rd; ram_sb = sb; ram_db = db;
        #1;
    endtask

    task automatic idle();
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'd0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        c_ren = 0; c_raddr = '0; c_wen = 0; c_waddr = '0; c_wd = '0;
        irq_clr = 0; ram_rd = '0; ram_sb = 0; ram_db = 0;
        RESETN = 0;
        @(negedge CLK);
        RESETN = 1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge CLK);
        c_ren = 0; c_raddr = '0; c_wen = 0; c_waddr = '0; c_wd = '0;
        irq_clr = 0; ram_rd = '0; ram_sb = 0; ram_db = 0;
        RESETN = 0;
        #1;
        checks++;
        if ({c_rvalid, c_rerr, ram_wen, db_irq, scrub_drop} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {c_rvalid, c_rerr, ram_wen, db_irq, scrub_drop});
        end
        checks++;
        if ({sb_cnt, db_cnt, db_addr, ram_raddr, c_rd} !== '0) begin
            errors++; $display("FAIL reset_values sb %0d db %0d daddr %0h raddr %0h rd %0h exp all 0",
                               sb_cnt, db_cnt, db_addr, ram_raddr, c_rd);
        end
        @(negedge CLK);
        RESETN = 1;
        model_reset();
    endtask

    task automatic test_clean_read();
        apply_reset();
        cyc(1, 7'd5, 0, 7'd0, 20'd0, 0, 20'd0, 0, 0);
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'h12345, 0, 0);
        checks++;
        if (c_rvalid !== 1'b1 || c_rd !== 20'h12345 || c_rerr !== 1'b0) begin
            errors++; $display("FAIL clean_read rvalid %b rd %h rerr %b exp 1 12345 0", c_rvalid, c_rd, c_rerr);
        end
        // SB flag with no read outstanding must be ignored.
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'h00FFF, 1, 0);
        checks++;
        if (c_rvalid !== 1'b0 || sb_cnt !== 8'd0 || ram_wen !== 1'b0) begin
            errors++; $display("FAIL clean_after rvalid %b sb %0d wen %b exp 0 0 0", c_rvalid, sb_cnt, ram_wen);
        end
        idle();
        checks++;
        if (sb_cnt !== 8'd0 || ram_wen !== 1'b0) begin
            errors++; $display("FAIL stray_sb sb %0d wen %b exp 0 0", sb_cnt, ram_wen);
        end
    endtask

    task automatic test_scrub_writeback();
        apply_reset();
        cyc(1, 7'd9, 0, 7'd0, 20'd0, 0, 20'd0, 0, 0);
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'hABCDE, 1, 0);
        checks++;
        if (c_rvalid !== 1'b1 || c_rerr !== 1'b0 || ram_wen !== 1'b0) begin
            errors++; $display("FAIL sb_read rvalid %b rerr %b wen %b exp 1 0 0", c_rvalid, c_rerr, ram_wen);
        end
        idle();
        checks++;
        if (ram_wen !== 1'b1 || ram_waddr !== 7'd9 || ram_wd !== 20'hABCDE || sb_cnt !== 8'd1) begin
            errors++; $display("FAIL scrub_wb wen %b addr %0d wd %h sb %0d exp 1 9 abcde 1",
                               ram_wen, ram_waddr, ram_wd, sb_cnt);
        end
        idle();
        checks++;
        if (ram_wen !== 1'b0) begin
            errors++; $display("FAIL scrub_done wen %b exp 0", ram_wen);
        end
    endtask

    task automatic test_scrub_cancel();
        apply_reset();
        cyc(1, 7'd9, 0, 7'd0, 20'd0, 0, 20'd0, 0, 0);
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'h11111, 1, 0);
        cyc(0, 7'd0, 1, 7'd9, 20'h22222, 0, 20'd0, 0, 0);
        checks++;
        if (ram_wen !== 1'b1 || ram_waddr !== 7'd9 || ram_wd !== 20'h22222) begin
            errors++; $display("FAIL cancel_client wen %b addr %0d wd %h exp 1 9 22222", ram_wen, ram_waddr, ram_wd);
        end
        idle();
        checks++;
        if (ram_wen !== 1'b0 || sb_cnt !== 8'd1) begin
            errors++; $display("FAIL cancel_idle wen %b sb %0d exp 0 1", ram_wen, sb_cnt);
        end
    endtask

    task automatic test_scrub_drop();
        int drops = 0;
        apply_reset();
        cyc(1, 7'd3, 0, 7'd0, 20'd0, 0, 20'd0, 0, 0);
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'h33333, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(k == 0, 7'd7, 1, 7'h20, 20'h0AAAA, 0, 20'h77777, k == 1, 0);
            drops += int'(scrub_drop);
            checks++;
            if (ram_wen !== 1'b1 || ram_waddr !== 7'h20) begin
                errors++; $display("FAIL drop_client k %0d wen %b addr %0h exp 1 20", k, ram_wen, ram_waddr);
            end
        end
        idle();
        drops += int'(scrub_drop);
        checks++;
        if (ram_wen !== 1'b1 || ram_waddr !== 7'd3 || ram_wd !== 20'h33333) begin
            errors++; $display("FAIL drop_wb wen %b addr %0d wd %h exp 1 3 33333", ram_wen, ram_waddr, ram_wd);
        end
        idle();
        drops += int'(scrub_drop);
        idle();
        drops += int'(scrub_drop);
        checks++;
        if (drops != 1 || sb_cnt !== 8'd2 || ram_wen !== 1'b0) begin
            errors++; $display("FAIL drop_count drops %0d sb %0d wen %b exp 1 2 0", drops, sb_cnt, ram_wen);
        end
    endtask

    task automatic test_db_log();
        apply_reset();
        cyc(1, 7'h44, 0, 7'd0, 20'd0, 0, 20'd0, 0, 0);
        cyc(1, 7'h10, 0, 7'd0, 20'd0, 0, 20'h0BAD0, 0, 1);
        checks++;
        if (c_rvalid !== 1'b1 || c_rerr !== 1'b1) begin
            errors++; $display("FAIL db_rerr rvalid %b rerr %b exp 1 1", c_rvalid, c_rerr);
        end
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'd0, 0, 1);
        checks++;
        if (db_irq !== 1'b1 || db_addr !== 7'h44) begin
            errors++; $display("FAIL db_first irq %b addr %0h exp 1 44", db_irq, db_addr);
        end
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 1, 20'd0, 0, 0);
        checks++;
        if (db_irq !== 1'b1 || db_addr !== 7'h44 || db_cnt !== 8'd2) begin
            errors++; $display("FAIL db_second irq %b addr %0h cnt %0d exp 1 44 2", db_irq, db_addr, db_cnt);
        end
        cyc(1, 7'h22, 0, 7'd0, 20'd0, 0, 20'd0, 0, 0);
        checks++;
        if (db_irq !== 1'b0 || db_cnt !== 8'd2) begin
            errors++; $display("FAIL db_clear irq %b cnt %0d exp 0 2", db_irq, db_cnt);
        end
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'd0, 0, 1);
        cyc(1, 7'h33, 0, 7'd0, 20'd0, 0, 20'd0, 0, 0);
        checks++;
        if (db_irq !== 1'b1 || db_addr !== 7'h22) begin
            errors++; $display("FAIL db_rearm irq %b addr %0h exp 1 22", db_irq, db_addr);
        end
        // Clear and a new DB (with SB also flagged) in the same cycle.
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 1, 20'h00001, 1, 1);
        idle();
        checks++;
        if (db_irq !== 1'b1 || db_addr !== 7'h33 || db_cnt !== 8'd4 || sb_cnt !== 8'd0 || ram_wen !== 1'b0) begin
            errors++; $display("FAIL db_clr_race irq %b addr %0h dcnt %0d scnt %0d wen %b exp 1 33 4 0 0",
                               db_irq, db_addr, db_cnt, sb_cnt, ram_wen);
        end
    endtask

    task automatic test_reset_mid_scrub();
        apply_reset();
        cyc(1, 7'h0B, 0, 7'd0, 20'd0, 0, 20'd0, 0, 0);
        cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'h5A5A5, 1, 0);
        cyc(0, 7'd0, 1, 7'h30, 20'h0000C, 0, 20'd0, 0, 0);
        @(negedge CLK);
        c_wen = 0;
        RESETN = 0;
        #1;
        checks++;
        if (ram_wen !== 1'b0 || sb_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_mid_scrub wen %b sb %0d exp 0 0", ram_wen, sb_cnt);
        end
        apply_reset();
        idle();
        checks++;
        if (ram_wen !== 1'b0) begin
            errors++; $display("FAIL reset_no_resume wen %b exp 0", ram_wen);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 300; k++) cyc(1, 7'd1, 0, 7'd0, 20'd0, 0, 20'h0F0F0, 1, 0);
        idle();
        checks++;
        if (sb_cnt !== 8'hFF) begin
            errors++; $display("FAIL sb_saturate got %0d exp 255", sb_cnt);
        end
        for (int k = 0; k < 300; k++) cyc(1, 7'd2, 0, 7'd0, 20'd0, 0, 20'd0, 0, 1);
        idle();
        checks++;
        if (db_cnt !== 8'hFF || sb_cnt !== 8'hFF) begin
            errors++; $display("FAIL db_saturate db %0d sb %0d exp 255 255", db_cnt, sb_cnt);
        end
    endtask

    task automatic test_random();
        bit exp_wen;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 6, 7'($urandom_range(0, 7)),
                $urandom_range(0, 9) < 4, 7'($urandom_range(0, 7)), 20'($urandom),
                $urandom_range(0, 19) == 0, 20'($urandom),
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
            exp_wen = c_wen || m_pend;
            checks++;
            if (c_rvalid !== m_rd || (m_rd && c_rd !== ram_rd)) begin
                errors++; $display("FAIL rnd_read cyc %0d rvalid %b rd %h exp %b %h", i, c_rvalid, c_rd, m_rd, ram_rd);
            end
            checks++;
            if (c_rerr !== (m_rd && ram_db)) begin
                errors++; $display("FAIL rnd_rerr cyc %0d got %b exp %b", i, c_rerr, m_rd && ram_db);
            end
            checks++;
            if (ram_raddr !== c_raddr) begin
                errors++; $display("FAIL rnd_raddr cyc %0d got %0h exp %0h", i, ram_raddr, c_raddr);
            end
            checks++;
            if (ram_wen !== exp_wen) begin
                errors++; $display("FAIL rnd_wen cyc %0d got %b exp %b", i, ram_wen, exp_wen);
            end
            checks++;
            if (exp_wen && (ram_waddr !== (c_wen ? c_waddr : m_paddr) || ram_wd !== (c_wen ? c_wd : m_pdata))) begin
                errors++; $display("FAIL rnd_wport cyc %0d addr %0h wd %h exp %0h %h", i, ram_waddr, ram_wd,
                                   c_wen ? c_waddr : m_paddr, c_wen ? c_wd : m_pdata);
            end
            checks++;
            if (sb_cnt !== m_sb || db_cnt !== m_db) begin
                errors++; $display("FAIL rnd_cnt cyc %0d sb %0d db %0d exp %0d %0d", i, sb_cnt, db_cnt, m_sb, m_db);
            end
            checks++;
            if (db_irq !== m_irq || (m_irq && db_addr !== m_daddr)) begin
                errors++; $display("FAIL rnd_dblog cyc %0d irq %b addr %0h exp %b %0h", i, db_irq, db_addr, m_irq, m_daddr);
            end
            checks++;
            if (scrub_drop !== m_drop) begin
                errors++; $display("FAIL rnd_drop cyc %0d got %b exp %b", i, scrub_drop, m_drop);
            end
        end
    endtask

    task automatic test_bg_walker();
        int nwr = 0;
        int exp_addr = 0;
        apply_reset();
        // Every background read reports SB, so each one becomes a visible write-back.
        for (int i = 0; i < 3000 && nwr < 129; i++) begin
            cyc(0, 7'd0, 0, 7'd0, 20'd0, 0, 20'($urandom), 1, 0);
            checks++;
            if (c_rvalid !== 1'b0) begin
                errors++; $display("FAIL bg_rvalid cyc %0d got %b exp 0", i, c_rvalid);
            end
            if (ram_wen === 1'b1) begin
                checks++;
                if (ram_waddr !== 7'(exp_addr)) begin
                    errors++; $display("FAIL bg_addr n %0d got %0d exp %0d", nwr, ram_waddr, exp_addr);
                end
                exp_addr = (exp_addr + 1) % 128;
                nwr++;
            end
        end
        checks++;
        if (nwr < 129) begin
            errors++; $display("FAIL bg_timeout writes %0d exp 129", nwr);
        end
    endtask

    initial begin
        c_ren = 0; c_raddr = '0; c_wen = 0; c_waddr = '0; c_wd = '0;
        irq_clr = 0; ram_rd = '0; ram_sb = 0; ram_db = 0;
        model_reset();
        test_reset();
`ifdef RAM_ECC_BG_SCRUB_EN
        test_bg_walker();
`else
        test_clean_read();
        test_scrub_writeback();
        test_scrub_cancel();
        test_scrub_drop();
        test_db_log();
        test_reset_mid_scrub();
        test_saturation();
        test_random();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
